// File: rtl/custmul_harness_checker.sv
// Self-checking driver for the custom-multiplier harness: issues LFSR operand
// vectors, predicts products and register-chain bits, and counts mismatches.
module custmul_harness_checker #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [127:0] in_vec,
  input  logic [127:0] out_vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count,
  output logic [15:0]  first_err_idx
);

  localparam int unsigned IW  = 16;
  localparam int unsigned PW  = 16;
  localparam int unsigned DCW = 4;
  localparam logic [IW-1:0]  LAST_IDX   = IW'(NUM_VECTORS - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(LATENCY - 1);
  localparam logic [IW-1:0]  NO_ERR     = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    logic [PW-1:0] exp;
  } pipe_t;

  typedef struct packed {
    logic          valid;
    logic          a0;
    logic [IW-1:0] idx;
  } hist_t;

  state_e         state_q, state_d;
  logic [31:0]    lfsr_q, lfsr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [DCW-1:0] drain_q, drain_d;
  pipe_t          pipe_q [LATENCY];
  pipe_t          pipe_d [LATENCY];
  hist_t          h1_q, h1_d, h2_q, h2_d;
  logic [15:0]    err_q, err_d;
  logic [IW-1:0]  first_q, first_d;
  logic [127:0]   in_vec_q, in_vec_d;
  logic           busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic  accept, running, checking;
  logic  prod_fail, r1_fail, r2_fail, any_fail;
  pipe_t pipe_out;
  logic  unused_ok;

  function automatic logic [127:0] pack_vec(input logic [31:0] l);
    logic [127:0] v;
    v        = '0;
    v[15:0]  = l[15:0];
    v[47:32] = l[31:16];
    return v;
  endfunction

  assign unused_ok = ^out_vec[111:2];

  // Compare stage: product at the pipeline tail, register chain at fixed depth 1 and 2.
  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign running   = (state_q == S_RUN);
  assign checking  = running || (state_q == S_DRAIN);
  assign pipe_out  = pipe_q[LATENCY-1];
  assign prod_fail = checking && pipe_out.valid && (out_vec[127:112] != pipe_out.exp);
  assign r1_fail   = checking && h1_q.valid && (out_vec[0] != h1_q.a0);
  assign r2_fail   = checking && h2_q.valid && (out_vec[1] != h2_q.a0);
  assign any_fail  = prod_fail || r1_fail || r2_fail;

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    drain_d   = drain_q;
    err_d     = err_q;
    first_d   = first_q;
    h1_d      = '{valid: running, a0: lfsr_q[0], idx: idx_q};
    h2_d      = h1_q;
    pipe_d[0] = '{valid: running, idx: idx_q, exp: PW'(lfsr_q[15:0] * lfsr_q[31:16])};
    for (int i = 1; i < int'(LATENCY); i++) pipe_d[i] = pipe_q[i-1];

    if (any_fail) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (first_q == NO_ERR)
        first_d = prod_fail ? pipe_out.idx : (r2_fail ? h2_q.idx : h1_q.idx);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_RUN;
          lfsr_d  = SEED;
          idx_d   = '0;
          err_d   = '0;
          first_d = NO_ERR;
          h2_d.valid = 1'b0;
          for (int i = 0; i < int'(LATENCY); i++) pipe_d[i].valid = 1'b0;
        end
      end
      S_RUN: begin
        // Fibonacci taps 32,22,2,1
        lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = S_DONE;
        else                       drain_d = drain_q + DCW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    in_vec_d = (state_d == S_RUN) ? pack_vec(lfsr_d) : '0;
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    pass_d   = done_d && (err_d == 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      drain_q  <= '0;
      err_q    <= '0;
      first_q  <= NO_ERR;
      h1_q     <= '0;
      h2_q     <= '0;
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= '0;
      in_vec_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      first_q  <= first_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      for (int i = 0; i < int'(LATENCY); i++) pipe_q[i] <= pipe_d[i];
      in_vec_q <= in_vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign in_vec        = in_vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_custmul_harness_checker.sv
// Directed bench: behavioural harness models with injectable faults around two checker instances.
module tb_custmul_harness_checker;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int N1 = 16;
  localparam int N2 = 65535;

  logic clk, rst, start1, start2;
  logic [127:0] in1, out1, in2, out2;
  logic busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] err1, first1, err2, first2;

  int total, bad;
  int mode;  // 0 ideal, 1 corrupt vector 5, 2 product one cycle late

  custmul_harness_checker #(.LATENCY(1), .NUM_VECTORS(N1), .SEED(SEED)) u_dut (
    .clk(clk), .rst(rst), .start(start1), .in_vec(in1), .out_vec(out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_idx(first1));

  custmul_harness_checker #(.LATENCY(1), .NUM_VECTORS(N2), .SEED(SEED)) u_big (
    .clk(clk), .rst(rst), .start(start2), .in_vec(in2), .out_vec(out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_idx(first2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Harness model for u_dut
  logic [15:0] hp1, hp2, hcnt;
  logic hr1, hr2, corrupt_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hp1 <= '0; hp2 <= '0; hr1 <= 1'b0; hr2 <= 1'b0; hcnt <= '0; corrupt_q <= 1'b0;
    end else begin
      hp1 <= 16'(in1[15:0] * in1[47:32]);
      hp2 <= hp1;
      hr1 <= in1[0];
      hr2 <= hr1;
      hcnt <= (start1 && !busy1) ? 16'd0 : hcnt + 16'd1;
      corrupt_q <= (mode == 1) && (hcnt == 16'd5) && busy1;
    end
  end
  assign out1 = {(mode == 2) ? hp2 : (hp1 ^ {15'd0, corrupt_q}), 110'd0, hr2, hr1};

  // Harness model for u_big: second register stage stuck at 0
  logic [15:0] gp1;
  logic gr1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gp1 <= '0; gr1 <= 1'b0;
    end else begin
      gp1 <= 16'(in2[15:0] * in2[47:32]);
      gr1 <= in2[0];
    end
  end
  assign out2 = {gp1, 110'd0, 1'b0, gr1};

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  function automatic logic [127:0] vec_of(input logic [31:0] l);
    logic [127:0] v;
    v = '0;
    v[15:0]  = l[15:0];
    v[47:32] = l[31:16];
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start a run on u_dut, check the in_vec sequence, return the cycle done was seen.
  task automatic run1(input int pulse_at, output int done_cyc);
    logic [31:0] l;
    l = SEED;
    done_cyc = -1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c < N1) begin
        chk("in_vec_seq", in1, vec_of(l));
        l = lfsr_next(l);
      end
      start1 = (c == pulse_at);
      if (done1) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("in_vec_zero_done", in1, 128'd0);
  endtask

  typedef struct {
    string       name;
    int          mode;
    int          pulse_at;
    int          exp_done;
    int          min_err;
    int          max_err;
    logic [15:0] exp_first;
    logic        exp_pass;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int dc;
    logic [31:0] l;
    int odd_cnt;
    logic [15:0] odd_first;
    int ok;

    total = 0; bad = 0; mode = 0;
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;

    tbl[0] = '{"ideal",      0, -1, 17, 0,  0,  16'hFFFF, 1'b1};
    tbl[1] = '{"corrupt5",   1, -1, 17, 1,  1,  16'd5,    1'b0};
    tbl[2] = '{"late_prod",  2, -1, 17, 15, 16, 16'd0,    1'b0};
    tbl[3] = '{"busy_start", 0,  8, 17, 0,  0,  16'hFFFF, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_in_vec", in1, 128'd0);
    chk("rst_busy", {127'd0, busy1}, 128'd0);
    chk("rst_done", {127'd0, done1}, 128'd0);
    chk("rst_pass", {127'd0, pass1}, 128'd0);
    chk("rst_err", {112'd0, err1}, 128'd0);
    chk("rst_first", {112'd0, first1}, {112'd0, 16'hFFFF});
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      mode = tbl[t].mode;
      run1(tbl[t].pulse_at, dc);
      chk({tbl[t].name, "_done_cycle"}, 128'(dc), 128'(tbl[t].exp_done));
      ok = (int'(err1) >= tbl[t].min_err && int'(err1) <= tbl[t].max_err) ? 1 : 0;
      if (ok == 0) $display("FAIL %s_err_range actual=%0d required=%0d..%0d",
                            tbl[t].name, err1, tbl[t].min_err, tbl[t].max_err);
      total++;
      if (ok == 0) bad++;
      chk({tbl[t].name, "_first"}, {112'd0, first1}, {112'd0, tbl[t].exp_first});
      chk({tbl[t].name, "_pass"}, {127'd0, pass1}, {127'd0, tbl[t].exp_pass});
      chk({tbl[t].name, "_busy"}, {127'd0, busy1}, 128'd0);
      @(negedge clk);
    end

    // Abort a faulty run with reset at cycle 10, then rerun clean.
    mode = 1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_err_before", {112'd0, err1}, {112'd0, 16'd1});
    rst = 1'b1;
    #1;
    chk("abort_in_vec", in1, 128'd0);
    chk("abort_busy", {127'd0, busy1}, 128'd0);
    chk("abort_err", {112'd0, err1}, 128'd0);
    chk("abort_first", {112'd0, first1}, {112'd0, 16'hFFFF});
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {127'd0, busy1}, 128'd0);
    chk("post_rst_err", {112'd0, err1}, 128'd0);
    chk("post_rst_in_vec", in1, 128'd0);
    mode = 0;
    run1(-1, dc);
    chk("rerun_done_cycle", 128'(dc), 128'd17);
    chk("rerun_err", {112'd0, err1}, 128'd0);
    chk("rerun_first", {112'd0, first1}, {112'd0, 16'hFFFF});
    chk("rerun_pass", {127'd0, pass1}, 128'd1);

    // Long run with out_vec[1] stuck at 0: each odd A whose 2-cycle check lands while busy fails once.
    l = SEED; odd_cnt = 0; odd_first = 16'hFFFF;
    for (int i = 0; i <= N2 - 2; i++) begin
      if (l[0]) begin
        if (odd_cnt == 0) odd_first = 16'(i);
        odd_cnt++;
      end
      l = lfsr_next(l);
    end
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    dc = -1;
    for (int c = 0; c < 70000; c++) begin
      if (done2) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    chk("stuck_done_cycle", 128'(dc), 128'(N2 + 1));
    chk("stuck_err", {112'd0, err2}, 128'(odd_cnt));
    chk("stuck_first", {112'd0, first2}, {112'd0, odd_first});
    chk("stuck_pass", {127'd0, pass2}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/custmul_harness_checker.md
CUSTMUL_HARNESS_CHECKER -- requirements
Module: custmul_harness_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 1: clock edges from a vector appearing on in_vec to its product appearing on out_vec[127:112]; range 1..8.
REQ-002 SHALL have parameter NUM_VECTORS, default 256: vectors issued per run; range 1..65535.
REQ-003 SHALL have parameter SEED, default 32'hACE1_2468: LFSR load value; SHALL be nonzero.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE or DONE.
REQ-007 SHALL have port in_vec, output, 128 bits: drives the harness IN bus.
REQ-008 SHALL have port out_vec, input, 128 bits: receives the harness OUT bus.
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-010 SHALL have port done, output, 1 bit: high in DONE.
REQ-011 SHALL have port pass, output, 1 bit: equals done AND (err_count == 0).
REQ-012 SHALL have port err_count, output, 16 bits: mismatch count for the current or last run.
REQ-013 SHALL have port first_err_idx, output, 16 bits: vector index of the first mismatch; 16'hFFFF if none.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DRAIN after NUM_VECTORS issue cycles; DRAIN->DONE after LATENCY cycles; DONE holds until start.
REQ-015 SHALL ignore start while busy.
REQ-016 On the edge that accepts start: LFSR loaded with SEED; vector index, err_count and history cleared; first_err_idx set to 16'hFFFF.
REQ-017 SHALL use a 32-bit Fibonacci LFSR, taps 32,22,2,1, advancing once per RUN cycle; A = lfsr[15:0], B = lfsr[31:16].
REQ-018 In RUN, in_vec[15:0] = A and in_vec[47:32] = B; all other in_vec bits SHALL be 0; in_vec SHALL be all zero outside RUN.
REQ-019 Expected product = (A * B) mod 2^16, unsigned.
REQ-020 SHALL keep a LATENCY-deep tagged pipeline (valid, index, expected); entries issued in RUN carry valid=1, other cycles valid=0.
REQ-021 When the pipeline output is valid, out_vec[127:112] SHALL be compared with its expected value in that cycle.
REQ-022 SHALL also check the register chain: out_vec[0] equals the A[0] issued 1 cycle earlier, and out_vec[1] equals the A[0] issued 2 cycles earlier, only when the corresponding issue cycle was a RUN cycle.
REQ-023 A cycle with any failing check SHALL increment err_count by exactly 1; err_count saturates at 16'hFFFF.
REQ-024 first_err_idx SHALL capture the index of the product check's vector on the first failing cycle, or the register-check vector if only a register check failed; further failures do not update it.
REQ-025 Vector index SHALL be 0 for the first vector and increment by 1 per RUN cycle.
REQ-026 DRAIN SHALL continue checking so the last vector is compared before DONE; no checks occur in IDLE or DONE.
REQ-027 done SHALL rise exactly NUM_VECTORS + LATENCY cycles after the start-accept edge.

Reset
REQ-028 On rst: state IDLE; in_vec = 0; busy, done and pass = 0; err_count = 0; first_err_idx = 16'hFFFF; LFSR = SEED; pipeline valid bits = 0.
REQ-029 rst during RUN or DRAIN SHALL abort the run immediately; no check occurs on the cycle in which rst is released.

Verification
REQ-030 Ideal harness model, LATENCY=1, NUM_VECTORS=16 -> done after 17 cycles, pass=1, err_count=0, first_err_idx=16'hFFFF.
REQ-031 Model corrupts the product of vector 5 (bit 112 flipped) -> err_count=1, first_err_idx=5, pass=0.
REQ-032 Model delays the product by one extra cycle while LATENCY=1 -> err_count >= 15, first_err_idx=0.
REQ-033 Pulse start while busy at cycle 8 -> no restart; done still at cycle 17.
REQ-034 Assert rst at cycle 10 of a run, release it, then restart -> IDLE with in_vec=0 after reset; the second run matches REQ-030 exactly, with identical in_vec sequence.
REQ-035 Model holds out_vec[1] stuck at 0, NUM_VECTORS=65535 -> err_count equals the number of odd A values, first_err_idx equals the first odd-A index, no wrap.
